// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one iterative fp unit among NREQ requesters, with a completion watchdog
module fp_unit_arbiter #(
  parameter int NX = 8,
  parameter int NM = 23,
  parameter int NREQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*(NX+NM+1)-1:0] req_a,
  input  logic [NREQ*(NX+NM+1)-1:0] req_b,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [NX+NM:0]           rsp_result,
  output logic                     rsp_err,
  output logic                     u_start,
  output logic [NX+NM:0]           u_a,
  output logic [NX+NM:0]           u_b,
  input  logic                     u_done,
  input  logic [NX+NM:0]           u_result,
  output logic                     busy
);
  localparam int N = NX + NM + 1;
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [N-1:0] QNAN = {1'b0, {NX{1'b1}}, 1'b1, {(NM-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gnt;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_rsp_result;
  logic            r_rsp_err;
  logic [N-1:0]    r_u_a;
  logic [N-1:0]    r_u_b;
  logic            w_found;
  logic [PW-1:0]   w_win;

  // index arithmetic that wraps explicitly so non-power-of-two NREQ works
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return PW'(s >= NREQ ? s - NREQ : s);
  endfunction

  // round-robin winner: first valid requester starting at the pointer
  always_comb begin
    w_found = 1'b0;
    w_win = r_ptr;
    for (int k = 0; k < NREQ; k++)
      if (!w_found && req_valid[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win = wrap_add(r_ptr, k);
      end
  end

  assign req_ready  = (r_state == IDLE && w_found) ? NREQ'(1) << w_win : '0;
  assign rsp_valid  = (r_state == RESP) ? NREQ'(1) << r_gnt : '0;
  assign u_start    = r_state == ISSUE;
  assign busy       = r_state != IDLE;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign u_a        = r_u_a;
  assign u_b        = r_u_b;

  // grant, issue, wait for completion or watchdog, then hold the response until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_gnt <= '0;
      r_cnt <= '0;
      r_rsp_result <= '0;
      r_rsp_err <= 1'b0;
      r_u_a <= '0;
      r_u_b <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (w_found) begin
            r_u_a <= req_a[w_win*N +: N];
            r_u_b <= req_b[w_win*N +: N];
            r_gnt <= w_win;
            r_state <= ISSUE;
          end
        ISSUE: begin
          r_cnt <= '0;
          r_state <= WAIT;
        end
        WAIT:
          if (u_done) begin
            r_rsp_result <= u_result;
            r_rsp_err <= 1'b0;
            r_state <= RESP;
          end else if (TIMEOUT != 0 && r_cnt == TMAX) begin
            r_rsp_result <= QNAN;
            r_rsp_err <= 1'b1;
            r_state <= RESP;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        RESP:
          if (rsp_ready[r_gnt]) begin
            r_ptr <= wrap_add(r_gnt, 1);
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter: randomized scoreboard bench for fp_unit_arbiter with a latency-programmable unit model
module tb_fp_unit_arbiter;
  localparam int NX = 8;
  localparam int NM = 23;
  localparam int N = 32;
  localparam int NREQ = 4;
  localparam int TO = 8;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready = '1;
  logic [N-1:0] rsp_result;
  logic rsp_err;
  logic u_start;
  logic [N-1:0] u_a;
  logic [N-1:0] u_b;
  logic u_done = 1'b0;
  logic [N-1:0] u_result = '0;
  logic busy;

  fp_unit_arbiter #(.NX(NX), .NM(NM), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .u_start(u_start), .u_a(u_a), .u_b(u_b), .u_done(u_done), .u_result(u_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int ntests = 0;
  int nfail = 0;

  // unit behaviour knobs, changed only just after a rising edge
  int lat = 3;
  bit force_on = 1'b0;
  logic [31:0] force_val = '0;
  int spur_req = 0;
  int stall_ev = 0;

  function automatic logic [31:0] ufunc(input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + 32'h0001_2345;
  endfunction

  // unit model: done strobe lat cycles after start, lat==0 never completes
  int rem = 0;
  int spur_seen = 0;
  logic [31:0] u_res_l = '0;
  always @(negedge clk) begin
    u_done = 1'b0;
    if (rst) rem = 0;
    else if (u_start) begin
      rem = lat;
      u_res_l = force_on ? force_val : ufunc(u_a, u_b);
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        u_done = 1'b1;
        u_result = u_res_l;
      end
    end
    if (spur_req != spur_seen) begin
      spur_seen = spur_req;
      u_done = 1'b1;
      u_result = 32'hDEADBEEF;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int idx;
    logic [31:0] res;
    logic err;
    int t;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit armed = 1'b0;
  bit prev_rst = 1'b0;
  bit active = 1'b0;
  int m_ptr = 0;
  int m_gnt = 0;
  int t_acc = 0;
  int w;
  int stall_seen = 0;
  bit tmo;
  logic [31:0] ea = '0;
  logic [31:0] eb = '0;
  logic [31:0] m_ua = '0;
  logic [31:0] m_ub = '0;

  // reference model and monitor: round-robin from the model pointer, timing from spec latencies
  always @(negedge clk) begin
    if (rst) begin
      armed = 1'b1;
      prev_rst = 1'b1;
      active = 1'b0;
      m_ptr = 0;
      m_ua = '0;
      m_ub = '0;
      q.delete();
    end else if (armed) begin
      if (prev_rst) begin
        chk("reset_result", rsp_result, 0);
        chk("reset_err", rsp_err, 0);
        prev_rst = 1'b0;
      end
      if (stall_ev != stall_seen) begin
        chk("wait_budget", stall_ev, stall_seen);
        stall_seen = stall_ev;
      end
      chk("busy", busy, active);
      chk("u_start", u_start, active && cyc == t_acc + 1);
      chk("u_a", u_a, m_ua);
      chk("u_b", u_b, m_ub);
      w = -1;
      if (!active)
        for (int o = 0; o < NREQ; o++)
          if (w < 0 && req_valid[(m_ptr + o) % NREQ]) w = (m_ptr + o) % NREQ;
      chk("req_ready", req_ready, w >= 0 ? 64'(1) << w : 64'(0));
      if (active && cyc == t_acc + 1) begin
        tmo = lat == 0 || lat > TO;
        e.idx = m_gnt;
        e.err = tmo;
        e.res = tmo ? QNAN : (force_on ? force_val : ufunc(ea, eb));
        e.t = t_acc + 2 + (tmo ? TO : lat);
        q.push_back(e);
      end
      if (q.size() > 0 && cyc >= q[0].t) begin
        chk("rsp_valid", rsp_valid, 64'(1) << q[0].idx);
        chk("rsp_result", rsp_result, q[0].res);
        chk("rsp_err", rsp_err, q[0].err);
        if (rsp_ready[q[0].idx]) begin
          m_ptr = (q[0].idx + 1) % NREQ;
          active = 1'b0;
          void'(q.pop_front());
        end
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
      end
      if (w >= 0) begin
        active = 1'b1;
        t_acc = cyc;
        m_gnt = w;
        ea = req_a[w*N +: N];
        eb = req_b[w*N +: N];
        m_ua = ea;
        m_ub = eb;
      end
    end
  end

  logic [NREQ-1:0] hs = '0;
  bit refill = 1'b0;

  task automatic setreq(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid[i] = 1'b1;
  endtask

  // one cycle of requester behaviour: drop valid after a handshake, optionally re-request
  task automatic tick();
    @(negedge clk);
    hs = rst ? '0 : (req_valid & req_ready);
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
    if (refill)
      for (int i = 0; i < NREQ; i++)
        if (hs[i]) setreq(i, $urandom, $urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req_valid != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) stall_ev++;
    tick();
  endtask

  task automatic wait_grant(input int i);
    for (int n = 0; n < 60; n++) begin
      tick();
      if (hs[i]) return;
    end
    stall_ev++;
  endtask

  task automatic wait_rsp(input int i);
    for (int n = 0; n < 60; n++) begin
      if (rsp_valid[i]) return;
      tick();
    end
    stall_ev++;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    // single op, unit returns 3.0 for 1.0 + 2.0
    lat = 3;
    force_on = 1'b1;
    force_val = 32'h40400000;
    setreq(0, 32'h3F800000, 32'h40000000);
    wait_idle(50);
    force_on = 1'b0;
    // fairness with every requester continuously asking
    lat = 2;
    refill = 1'b1;
    for (int i = 0; i < NREQ; i++) setreq(i, $urandom, $urandom);
    begin
      int g = 0;
      int n = 0;
      while (g < 5 && n < 100) begin
        tick();
        g += $countones(hs);
        n++;
      end
      if (n >= 100) stall_ev++;
    end
    refill = 1'b0;
    wait_idle(100);
    // backpressure on requester 2 while requester 0 waits
    rsp_ready = '1;
    rsp_ready[2] = 1'b0;
    setreq(2, $urandom, $urandom);
    wait_grant(2);
    setreq(0, $urandom, $urandom);
    repeat (16) tick();
    rsp_ready[2] = 1'b1;
    wait_idle(100);
    // watchdog, then a normal op
    lat = 0;
    setreq(1, $urandom, $urandom);
    wait_idle(60);
    lat = 3;
    setreq(1, $urandom, $urandom);
    wait_idle(60);
    // done on the last watchdog cycle, spurious done in IDLE and RESP
    lat = TO;
    force_on = 1'b1;
    force_val = 32'h40A00000;
    spur_req++;
    tick();
    rsp_ready[3] = 1'b0;
    setreq(3, $urandom, $urandom);
    wait_rsp(3);
    spur_req++;
    repeat (3) tick();
    rsp_ready[3] = 1'b1;
    wait_idle(60);
    force_on = 1'b0;
    // reset while waiting on the unit
    lat = 0;
    setreq(1, $urandom, $urandom);
    repeat (5) tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    spur_req++;
    tick();
    lat = 2;
    setreq(3, $urandom, $urandom);
    wait_idle(60);
    // random traffic
    for (int c = 0; c < 500; c++) begin
      tick();
      rsp_ready = NREQ'($urandom);
      lat = $urandom_range(0, 10);
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 9) < 3) setreq(i, $urandom, $urandom);
    end
    rsp_ready = '1;
    wait_idle(300);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
